// File: rtl/exe_stage.sv
// Execute pipeline stage: ALU, optional restoring divider (EXE_DIVIDER_EN),
// memory access address/alignment checks and data SRAM request generation.

module alu (
  input  logic [11:0] alu_op,
  input  logic [31:0] alu_src1,
  input  logic [31:0] alu_src2,
  output logic [31:0] alu_result
);

  // One-hot op: add sub slt sltu and nor or xor sll srl sra lui (bit 0 .. bit 11)
  logic [31:0] add_sub;
  logic        slt;
  logic        sltu;

  assign add_sub = alu_op[1] ? (alu_src1 - alu_src2) : (alu_src1 + alu_src2);
  assign slt     = $signed(alu_src1) < $signed(alu_src2);
  assign sltu    = alu_src1 < alu_src2;

  always_comb begin
    alu_result = 32'b0;
    unique case (1'b1)
      alu_op[0]:  alu_result = add_sub;
      alu_op[1]:  alu_result = add_sub;
      alu_op[2]:  alu_result = {31'b0, slt};
      alu_op[3]:  alu_result = {31'b0, sltu};
      alu_op[4]:  alu_result = alu_src1 & alu_src2;
      alu_op[5]:  alu_result = ~(alu_src1 | alu_src2);
      alu_op[6]:  alu_result = alu_src1 | alu_src2;
      alu_op[7]:  alu_result = alu_src1 ^ alu_src2;
      alu_op[8]:  alu_result = alu_src1 << alu_src2[4:0];
      alu_op[9]:  alu_result = alu_src1 >> alu_src2[4:0];
      alu_op[10]: alu_result = $signed(alu_src1) >>> alu_src2[4:0];
      alu_op[11]: alu_result = alu_src2;
      default:    alu_result = 32'b0;
    endcase
  end

endmodule

module exe_stage #(
  parameter int unsigned DS_TO_ES_BUS_WD = 160,
  parameter int unsigned ES_TO_MS_BUS_WD = 83,
  parameter int unsigned ES_FWD_BUS_WD   = 39
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ms_allowin,
  output logic                       es_allowin,
  input  logic                       ds_to_es_valid,
  input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
  output logic                       es_to_ms_valid,
  output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic [ES_FWD_BUS_WD-1:0]   es_fwd_bus,
  input  logic                       es_flush_pipe,
  input  logic                       ms_ex,
  output logic                       data_sram_en,
  output logic [3:0]                 data_sram_we,
  output logic [31:0]                data_sram_addr,
  output logic [31:0]                data_sram_wdata
);

  logic                       es_valid;
  logic                       es_ready_go;
  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus_q;

  logic        ex_in;
  logic [3:0]  div_op;
  logic [4:0]  load_op;
  logic [2:0]  store_op;
  logic        res_from_mem;
  logic        gr_we;
  logic [4:0]  dest;
  logic [11:0] alu_op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [31:0] store_data;
  logic [31:0] pc;

  assign {ex_in, div_op, load_op, store_op, res_from_mem, gr_we, dest, alu_op,
          src1, src2, store_data, pc} = ds_to_es_bus_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      es_valid <= 1'b0;
    end else if (es_flush_pipe) begin
      es_valid <= 1'b0;
    end else if (es_allowin) begin
      es_valid <= ds_to_es_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ds_to_es_bus_q <= '0;
    end else if (ds_to_es_valid && es_allowin) begin
      ds_to_es_bus_q <= ds_to_es_bus;
    end
  end

  assign es_allowin     = !es_valid || (es_ready_go && ms_allowin);
  assign es_to_ms_valid = es_valid && es_ready_go && !es_flush_pipe;

  logic [31:0] alu_result;
  logic [31:0] es_result;

  alu u_alu (
    .alu_op    (alu_op),
    .alu_src1  (src1),
    .alu_src2  (src2),
    .alu_result(alu_result)
  );

`ifdef EXE_DIVIDER_EN
  typedef enum logic [1:0] {StIdle, StBusy, StDone} div_state_e;

  div_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dsor_q, dsor_d;

  logic        is_div;
  logic        signed_op;
  logic        want_mod;
  logic        src1_neg;
  logic        src2_neg;
  logic [31:0] abs1;
  logic [31:0] abs2;
  logic [32:0] shifted;
  logic [32:0] diff;
  logic        ge;
  logic        div_zero;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  // A div carrying a decode exception never starts the divider.
  assign is_div    = (|div_op) && !ex_in;
  assign signed_op = div_op[3] | div_op[2];
  assign want_mod  = div_op[2] | div_op[0];
  assign src1_neg  = signed_op & src1[31];
  assign src2_neg  = signed_op & src2[31];
  assign abs1      = src1_neg ? (32'b0 - src1) : src1;
  assign abs2      = src2_neg ? (32'b0 - src2) : src2;
  assign shifted   = {rem_q, quo_q[31]};
  assign diff      = shifted - {1'b0, dsor_q};
  assign ge        = shifted >= {1'b0, dsor_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dsor_d  = dsor_q;
    unique case (state_q)
      StIdle: begin
        if (es_valid && is_div && !es_flush_pipe) begin
          state_d = StBusy;
          cnt_d   = 5'd0;
          rem_d   = 32'b0;
          quo_d   = abs1;
          dsor_d  = abs2;
        end
      end
      StBusy: begin
        rem_d = ge ? diff[31:0] : shifted[31:0];
        quo_d = {quo_q[30:0], ge};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = StDone;
      end
      StDone: begin
        if (es_to_ms_valid && ms_allowin) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (es_flush_pipe) state_d = StIdle;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 5'd0;
      rem_q   <= 32'b0;
      quo_q   <= 32'b0;
      dsor_q  <= 32'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dsor_q  <= dsor_d;
    end
  end

  // Operands stay in the input register while the divider runs, so the
  // sign fix-up reads them directly.
  assign div_zero = (src2 == 32'b0);
  assign quo_fix  = div_zero ? 32'hFFFF_FFFF :
                    ((src1_neg ^ src2_neg) ? (32'b0 - quo_q) : quo_q);
  assign rem_fix  = div_zero ? src1 : (src1_neg ? (32'b0 - rem_q) : rem_q);

  assign es_ready_go = !is_div || (state_q == StDone);
  assign es_result   = is_div ? (want_mod ? rem_fix : quo_fix) : alu_result;
`else
  logic unused_div_op;

  assign unused_div_op = ^div_op;
  assign es_ready_go   = 1'b1;
  assign es_result     = alu_result;
`endif

  logic       ld_w;
  logic       ld_h;
  logic       st_b;
  logic       st_h;
  logic       st_w;
  logic       is_mem;
  logic       misalign;
  logic       es_ex;
  logic [5:0] ecode;
  logic [3:0] we_raw;

  assign ld_w     = load_op[2];
  assign ld_h     = load_op[3] | load_op[0];
  assign st_b     = store_op[2];
  assign st_h     = store_op[1];
  assign st_w     = store_op[0];
  assign is_mem   = (|load_op) | (|store_op);
  assign misalign = ((ld_h | st_h) & alu_result[0]) |
                    ((ld_w | st_w) & (alu_result[1:0] != 2'b00));
  assign es_ex    = ex_in | misalign;
  // Decode exceptions carry their own ecode downstream; report 0 here.
  assign ecode    = ex_in ? 6'h00 : (misalign ? 6'h09 : 6'h00);

  always_comb begin
    we_raw          = 4'b0000;
    data_sram_wdata = store_data;
    if (st_b) begin
      we_raw          = 4'b0001 << alu_result[1:0];
      data_sram_wdata = {4{store_data[7:0]}};
    end else if (st_h) begin
      we_raw          = alu_result[1] ? 4'b1100 : 4'b0011;
      data_sram_wdata = {2{store_data[15:0]}};
    end else if (st_w) begin
      we_raw          = 4'b1111;
    end
  end

  assign data_sram_en   = es_valid && is_mem && !es_ex && !ms_ex && !es_flush_pipe;
  assign data_sram_we   = data_sram_en ? we_raw : 4'b0000;
  assign data_sram_addr = alu_result;

  assign es_to_ms_bus = {es_ex, ecode, load_op, res_from_mem, gr_we, dest, es_result, pc};
  assign es_fwd_bus   = {es_valid && res_from_mem, es_valid && gr_we, dest, es_result};

endmodule

// File: tb/tb_exe_stage.sv
// Directed self-checking bench for exe_stage; divider scenarios follow EXE_DIVIDER_EN.

module tb_exe_stage;

  logic         clk;
  logic         reset;
  logic         ms_allowin;
  logic         es_allowin;
  logic         ds_to_es_valid;
  logic [159:0] ds_to_es_bus;
  logic         es_to_ms_valid;
  logic [82:0]  es_to_ms_bus;
  logic [38:0]  es_fwd_bus;
  logic         es_flush_pipe;
  logic         ms_ex;
  logic         data_sram_en;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;

  int passed;
  int total;

  localparam logic [11:0] OpAdd = 12'h001;
  localparam logic [3:0]  DivW  = 4'b1000;
  localparam logic [3:0]  ModWu = 4'b0001;
  localparam logic [3:0]  DivWu = 4'b0010;
  localparam logic [4:0]  LdW   = 5'b00100;
  localparam logic [4:0]  LdH   = 5'b01000;
  localparam logic [2:0]  StB   = 3'b100;
  localparam logic [2:0]  StH   = 3'b010;
  localparam logic [2:0]  StW   = 3'b001;

  exe_stage dut (
    .clk            (clk),
    .reset          (reset),
    .ms_allowin     (ms_allowin),
    .es_allowin     (es_allowin),
    .ds_to_es_valid (ds_to_es_valid),
    .ds_to_es_bus   (ds_to_es_bus),
    .es_to_ms_valid (es_to_ms_valid),
    .es_to_ms_bus   (es_to_ms_bus),
    .es_fwd_bus     (es_fwd_bus),
    .es_flush_pipe  (es_flush_pipe),
    .ms_ex          (ms_ex),
    .data_sram_en   (data_sram_en),
    .data_sram_we   (data_sram_we),
    .data_sram_addr (data_sram_addr),
    .data_sram_wdata(data_sram_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [159:0] mk(input logic ex, input logic [3:0] dop,
                                      input logic [4:0] lop, input logic [2:0] sop,
                                      input logic rfm, input logic gwe,
                                      input logic [4:0] dst, input logic [31:0] s1,
                                      input logic [31:0] s2, input logic [31:0] sd);
    return {ex, dop, lop, sop, rfm, gwe, dst, OpAdd, s1, s2, sd, 32'h1c00_0000};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Latch one instruction, then drop ds_to_es_valid and settle.
  task automatic issue(input logic [159:0] b);
    ds_to_es_valid = 1'b1;
    ds_to_es_bus   = b;
    tick();
    ds_to_es_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ds_to_es_valid = 1'b1;
    ds_to_es_bus = mk(1'b0, 4'b0, 5'b0, StW, 1'b0, 1'b0, 5'd0, 32'h1000, 32'h0, 32'h0);
    tick();
    tick();
    ds_to_es_valid = 1'b0;
    #1;
    total++;
    if (es_to_ms_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", es_to_ms_valid);
    else passed++;
    total++;
    if (es_allowin !== 1'b1) $display("FAIL reset_allowin: got %b want 1", es_allowin);
    else passed++;
    total++;
    if (data_sram_en !== 1'b0) $display("FAIL reset_en: got %b want 0", data_sram_en);
    else passed++;
    total++;
    if (data_sram_we !== 4'b0) $display("FAIL reset_we: got %b want 0000", data_sram_we);
    else passed++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_alu();
    issue(mk(1'b0, 4'b0, 5'b0, 3'b0, 1'b0, 1'b1, 5'd5, 32'd3, 32'd4, 32'h0));
    total++;
    if (es_to_ms_valid !== 1'b1) $display("FAIL alu_valid: got %b want 1", es_to_ms_valid);
    else passed++;
    total++;
    if (es_to_ms_bus[63:32] !== 32'd7)
      $display("FAIL alu_result: got %h want 00000007", es_to_ms_bus[63:32]);
    else passed++;
    total++;
    if (es_fwd_bus !== {1'b0, 1'b1, 5'd5, 32'd7})
      $display("FAIL alu_fwd: got %h want %h", es_fwd_bus, {1'b0, 1'b1, 5'd5, 32'd7});
    else passed++;
    tick();
  endtask

  task automatic test_back_to_back();
    ds_to_es_valid = 1'b1;
    ds_to_es_bus = mk(1'b0, 4'b0, 5'b0, 3'b0, 1'b0, 1'b1, 5'd1, 32'd10, 32'd20, 32'h0);
    tick();
    ds_to_es_bus = mk(1'b0, 4'b0, 5'b0, 3'b0, 1'b0, 1'b1, 5'd2, 32'hFFFF_FFFF, 32'd2, 32'h0);
    total++;
    if (es_to_ms_bus[63:32] !== 32'd30 || es_to_ms_valid !== 1'b1)
      $display("FAIL b2b_first: got %h/%b want 0000001e/1", es_to_ms_bus[63:32], es_to_ms_valid);
    else passed++;
    tick();
    ds_to_es_valid = 1'b0;
    #1;
    total++;
    if (es_to_ms_bus[68:32] !== {5'd2, 32'd1})
      $display("FAIL b2b_second: got %h want %h", es_to_ms_bus[68:32], {5'd2, 32'd1});
    else passed++;
    tick();
  endtask

  task automatic test_store();
    issue(mk(1'b0, 4'b0, 5'b0, StB, 1'b0, 1'b0, 5'd0, 32'h1000, 32'h3, 32'h1234_5678));
    total++;
    if ({data_sram_en, data_sram_we, data_sram_wdata, data_sram_addr} !==
        {1'b1, 4'b1000, 32'h7878_7878, 32'h1003})
      $display("FAIL st_b: got en=%b we=%b wdata=%h addr=%h want 1/1000/78787878/00001003",
               data_sram_en, data_sram_we, data_sram_wdata, data_sram_addr);
    else passed++;
    tick();
    issue(mk(1'b0, 4'b0, 5'b0, StH, 1'b0, 1'b0, 5'd0, 32'h1000, 32'h2, 32'hAABB_CCDD));
    total++;
    if ({data_sram_en, data_sram_we, data_sram_wdata} !== {1'b1, 4'b1100, 32'hCCDD_CCDD})
      $display("FAIL st_h: got en=%b we=%b wdata=%h want 1/1100/ccddccdd",
               data_sram_en, data_sram_we, data_sram_wdata);
    else passed++;
    tick();
    issue(mk(1'b0, 4'b0, 5'b0, StW, 1'b0, 1'b0, 5'd0, 32'h1000, 32'h4, 32'hDEAD_BEEF));
    total++;
    if ({data_sram_en, data_sram_we, data_sram_wdata} !== {1'b1, 4'b1111, 32'hDEAD_BEEF})
      $display("FAIL st_w: got en=%b we=%b wdata=%h want 1/1111/deadbeef",
               data_sram_en, data_sram_we, data_sram_wdata);
    else passed++;
    tick();
  endtask

  task automatic test_load();
    issue(mk(1'b0, 4'b0, LdW, 3'b0, 1'b1, 1'b1, 5'd9, 32'h2000, 32'h0, 32'h0));
    total++;
    if ({data_sram_en, data_sram_we, es_fwd_bus[38], es_to_ms_bus[82]} !== {1'b1, 4'b0, 1'b1, 1'b0})
      $display("FAIL ld_w: got en=%b we=%b is_load=%b ex=%b want 1/0000/1/0",
               data_sram_en, data_sram_we, es_fwd_bus[38], es_to_ms_bus[82]);
    else passed++;
    tick();
    issue(mk(1'b0, 4'b0, LdH, 3'b0, 1'b1, 1'b1, 5'd9, 32'h2000, 32'h1, 32'h0));
    total++;
    if ({data_sram_en, es_to_ms_bus[82:76]} !== {1'b0, 1'b1, 6'h09})
      $display("FAIL ld_h_misalign: got en=%b ex=%b ecode=%h want 0/1/09",
               data_sram_en, es_to_ms_bus[82], es_to_ms_bus[81:76]);
    else passed++;
    tick();
  endtask

  task automatic test_exceptions();
    issue(mk(1'b0, 4'b0, 5'b0, StW, 1'b0, 1'b0, 5'd0, 32'h1000, 32'h2, 32'h1));
    total++;
    if ({es_to_ms_bus[82:76], data_sram_en, data_sram_we} !== {1'b1, 6'h09, 1'b0, 4'b0})
      $display("FAIL st_w_misalign: got ex=%b ecode=%h en=%b we=%b want 1/09/0/0000",
               es_to_ms_bus[82], es_to_ms_bus[81:76], data_sram_en, data_sram_we);
    else passed++;
    tick();
    issue(mk(1'b1, 4'b0, LdW, 3'b0, 1'b1, 1'b1, 5'd3, 32'h1000, 32'h2, 32'h0));
    total++;
    if ({es_to_ms_bus[82:76], data_sram_en, es_to_ms_valid} !== {1'b1, 6'h00, 1'b0, 1'b1})
      $display("FAIL ex_in: got ex=%b ecode=%h en=%b valid=%b want 1/00/0/1",
               es_to_ms_bus[82], es_to_ms_bus[81:76], data_sram_en, es_to_ms_valid);
    else passed++;
    tick();
    ms_ex = 1'b1;
    issue(mk(1'b0, 4'b0, 5'b0, StW, 1'b0, 1'b0, 5'd0, 32'h1000, 32'h4, 32'h1));
    total++;
    if ({data_sram_en, data_sram_we} !== {1'b0, 4'b0})
      $display("FAIL ms_ex_store: got en=%b we=%b want 0/0000", data_sram_en, data_sram_we);
    else passed++;
    ms_ex = 1'b0;
    tick();
  endtask

  task automatic test_flush_gate();
    issue(mk(1'b0, 4'b0, 5'b0, StW, 1'b0, 1'b1, 5'd4, 32'h1000, 32'h4, 32'h1));
    es_flush_pipe = 1'b1;
    #1;
    total++;
    if ({es_to_ms_valid, data_sram_en} !== 2'b00)
      $display("FAIL flush_gate: got valid=%b en=%b want 0/0", es_to_ms_valid, data_sram_en);
    else passed++;
    tick();
    es_flush_pipe = 1'b0;
    #1;
    total++;
    if ({es_to_ms_valid, es_fwd_bus[37], es_allowin} !== 3'b001)
      $display("FAIL flush_clear: got valid=%b fwd=%b allowin=%b want 0/0/1",
               es_to_ms_valid, es_fwd_bus[37], es_allowin);
    else passed++;
    tick();
  endtask

`ifdef EXE_DIVIDER_EN
  // Waits up to 60 cycles after latching; lat=0 means the result never came.
  task automatic run_div(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] res);
    issue(mk(1'b0, op, 5'b0, 3'b0, 1'b0, 1'b1, 5'd7, a, b, 32'h0));
    lat = 0;
    res = 32'hx;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (es_to_ms_valid) begin
        lat = k;
        res = es_to_ms_bus[63:32];
        break;
      end
    end
  endtask

  task automatic test_divider();
    int          lat;
    logic [31:0] res;
    issue(mk(1'b0, DivW, 5'b0, 3'b0, 1'b0, 1'b1, 5'd7, 32'hFFFF_FFF9, 32'h2, 32'h0));
    total++;
    if ({es_to_ms_valid, es_allowin} !== 2'b00)
      $display("FAIL div_stall: got valid=%b allowin=%b want 0/0", es_to_ms_valid, es_allowin);
    else passed++;
    lat = 0;
    res = 32'hx;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (es_to_ms_valid) begin
        lat = k;
        res = es_to_ms_bus[63:32];
        break;
      end
    end
    total++;
    if (lat !== 33) $display("FAIL div_w_latency: got %0d want 33", lat);
    else passed++;
    total++;
    if (res !== 32'hFFFF_FFFD) $display("FAIL div_w_result: got %h want fffffffd", res);
    else passed++;
    tick();
    run_div(ModWu, 32'd100, 32'd7, lat, res);
    total++;
    if (res !== 32'h2 || lat !== 33)
      $display("FAIL mod_wu: got res=%h lat=%0d want 00000002/33", res, lat);
    else passed++;
    tick();
    run_div(DivWu, 32'd5, 32'd0, lat, res);
    total++;
    if (res !== 32'hFFFF_FFFF || es_to_ms_bus[82] !== 1'b0)
      $display("FAIL div_zero: got res=%h ex=%b want ffffffff/0", res, es_to_ms_bus[82]);
    else passed++;
    tick();
    run_div(4'b0100, 32'hFFFF_FFF9, 32'h2, lat, res);
    total++;
    if (res !== 32'hFFFF_FFFF) $display("FAIL mod_w_signed: got %h want ffffffff", res);
    else passed++;
    tick();
  endtask

  task automatic test_div_flush();
    int seen;
    issue(mk(1'b0, DivW, 5'b0, 3'b0, 1'b0, 1'b1, 5'd7, 32'd50, 32'd3, 32'h0));
    for (int k = 1; k <= 10; k++) tick();
    es_flush_pipe = 1'b1;
    #1;
    total++;
    if (es_to_ms_valid !== 1'b0) $display("FAIL flush_busy_valid: got %b want 0", es_to_ms_valid);
    else passed++;
    tick();
    es_flush_pipe = 1'b0;
    #1;
    total++;
    if ({es_allowin, es_fwd_bus[37]} !== 2'b10)
      $display("FAIL flush_busy_clear: got allowin=%b fwd=%b want 1/0", es_allowin, es_fwd_bus[37]);
    else passed++;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (es_to_ms_valid) seen++;
    end
    total++;
    if (seen !== 0) $display("FAIL flush_busy_later: got %0d valid cycles want 0", seen);
    else passed++;
    // Divider must be idle again: a fresh division still takes 33 cycles.
    begin
      int          lat;
      logic [31:0] res;
      run_div(DivWu, 32'd50, 32'd3, lat, res);
      total++;
      if (res !== 32'd16 || lat !== 33)
        $display("FAIL after_flush_div: got res=%h lat=%0d want 00000010/33", res, lat);
      else passed++;
      tick();
    end
  endtask

  task automatic test_backpressure();
    int          lat;
    logic [31:0] res;
    int          bad;
    ms_allowin = 1'b0;
    run_div(DivWu, 32'd100, 32'd7, lat, res);
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      if (es_to_ms_valid !== 1'b1 || es_allowin !== 1'b0 || es_to_ms_bus[63:32] !== 32'd14)
        bad++;
      tick();
    end
    total++;
    if (lat !== 33 || bad !== 0)
      $display("FAIL backpressure_hold: got lat=%0d bad=%0d want 33/0", lat, bad);
    else passed++;
    ms_allowin = 1'b1;
    #1;
    tick();
    total++;
    if ({es_to_ms_valid, es_allowin} !== 2'b01)
      $display("FAIL backpressure_drain: got valid=%b allowin=%b want 0/1",
               es_to_ms_valid, es_allowin);
    else passed++;
  endtask
`else
  task automatic test_div_disabled();
    issue(mk(1'b0, DivW, 5'b0, 3'b0, 1'b0, 1'b1, 5'd7, 32'd9, 32'd2, 32'h0));
    total++;
    if ({es_to_ms_valid, es_to_ms_bus[63:32]} !== {1'b1, 32'd11})
      $display("FAIL div_disabled: got valid=%b res=%h want 1/0000000b",
               es_to_ms_valid, es_to_ms_bus[63:32]);
    else passed++;
    tick();
    ms_allowin = 1'b0;
    issue(mk(1'b0, 4'b0, 5'b0, 3'b0, 1'b0, 1'b1, 5'd1, 32'd1, 32'd1, 32'h0));
    total++;
    if ({es_to_ms_valid, es_allowin} !== 2'b10)
      $display("FAIL stall_no_div: got valid=%b allowin=%b want 1/0", es_to_ms_valid, es_allowin);
    else passed++;
    ms_allowin = 1'b1;
    tick();
  endtask
`endif

  initial begin
    passed         = 0;
    total          = 0;
    reset          = 1'b1;
    ms_allowin     = 1'b1;
    ds_to_es_valid = 1'b0;
    ds_to_es_bus   = '0;
    es_flush_pipe  = 1'b0;
    ms_ex          = 1'b0;
    test_reset();
    test_alu();
    test_back_to_back();
    test_store();
    test_load();
    test_exceptions();
    test_flush_gate();
`ifdef EXE_DIVIDER_EN
    test_divider();
    test_div_flush();
    test_backpressure();
`else
    test_div_disabled();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
